// File: rtl/beta_mc_ctrl.sv
`default_nettype none
// beta_mc_ctrl: multi-cycle BETA control FSM (fetch, decode, execute, ILL/INT vectoring via XP).
// Revision: 1.0
module beta_mc_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        mem_ack_i,
  input  logic        z_i,
  input  logic        irq_i,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic        imem_sel_o,
  output logic [4:0]  ra_o,
  output logic [4:0]  rb_o,
  output logic [4:0]  rc_o,
  output logic        ra2sel_o,
  output logic        wasel_o,
  output logic        werf_o,
  output logic        asel_o,
  output logic        bsel_o,
  output logic [3:0]  alufn_o,
  output logic [1:0]  wdsel_o,
  output logic [2:0]  pcsel_o,
  output logic        pc_en_o,
  output logic        irq_ack_o,
  output logic        illop_o,
  output logic        bus_err_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_ILL    = 3'd3;
  localparam logic [2:0] S_INT    = 3'd4;

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  // Only IR[31:11] is ever consumed (opcode, RC, RA, RB); the literal lives in the datapath.
  logic [2:0]    state_q, state_d;
  logic [31:11]  ir_q, ir_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          run_q;

  logic [5:0] opc_w;
  logic       is_alu_w, is_ld_w, is_st_w, is_ldr_w, is_jmp_w, is_beq_w, is_bne_w;
  logic       is_mem_w, legal_w;
  logic       req_w, ack_w, timeout_w;

  assign opc_w    = ir_q[31:26];
  assign is_alu_w = opc_w[5] && !(opc_w[3:0] inside {4'h7, 4'hB, 4'hF});
  assign is_ld_w  = (opc_w == 6'h18);
  assign is_st_w  = (opc_w == 6'h19);
  assign is_jmp_w = (opc_w == 6'h1B);
  assign is_beq_w = (opc_w == 6'h1C);
  assign is_bne_w = (opc_w == 6'h1D);
  assign is_ldr_w = (opc_w == 6'h1F);
  assign is_mem_w = is_ld_w || is_st_w || is_ldr_w;
  assign legal_w  = is_alu_w || is_mem_w || is_jmp_w || is_beq_w || is_bne_w;

  assign ra_o = ir_q[20:16];
  assign rb_o = ir_q[15:11];
  assign rc_o = ir_q[25:21];

  generate
    if (WAIT_MAX != 0) begin : g_timeout
      assign timeout_w = (wait_q == WAIT_LIM);
    end else begin : g_no_timeout
      assign timeout_w = 1'b0;
    end
  endgenerate

  // run_q keeps every output quiet until the first edge after reset release.
  assign req_w  = run_q && !timeout_w &&
                  ((state_q == S_FETCH) || ((state_q == S_EXEC) && is_mem_w));
  assign ack_w  = req_w && mem_ack_i;
  assign wait_d = (req_w && !mem_ack_i) ? wait_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          if (timeout_w) begin
            state_d = S_ILL;
          end else if (ack_w) begin
            ir_d    = instr_i[31:11];
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = legal_w ? S_EXEC : S_ILL;
        S_EXEC: begin
          if (!is_mem_w || ack_w) begin
            state_d = irq_i ? S_INT : S_FETCH;
          end else if (timeout_w) begin
            state_d = S_ILL;
          end
        end
        S_ILL:   state_d = irq_i ? S_INT : S_FETCH;
        S_INT:   state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    imem_sel_o = 1'b0;
    ra2sel_o   = 1'b0;
    wasel_o    = 1'b0;
    werf_o     = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    alufn_o    = 4'd0;
    wdsel_o    = 2'd0;
    pcsel_o    = 3'd0;
    pc_en_o    = 1'b0;
    irq_ack_o  = 1'b0;
    illop_o    = 1'b0;
    bus_err_o  = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          if (timeout_w) begin
            bus_err_o = 1'b1;
          end else begin
            mem_req_o  = 1'b1;
            imem_sel_o = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_alu_w) begin
            werf_o  = 1'b1;
            wdsel_o = 2'd1;
            bsel_o  = ir_q[30];
            alufn_o = ir_q[29:26];
            pc_en_o = 1'b1;
          end else if (is_jmp_w) begin
            werf_o  = 1'b1;
            pcsel_o = 3'd2;
            pc_en_o = 1'b1;
          end else if (is_beq_w || is_bne_w) begin
            werf_o  = 1'b1;
            pc_en_o = 1'b1;
            pcsel_o = (z_i ^ is_bne_w) ? 3'd1 : 3'd0;
          end else if (is_mem_w) begin
            if (timeout_w) begin
              bus_err_o = 1'b1;
            end else begin
              mem_req_o = 1'b1;
              bsel_o    = 1'b1;
              asel_o    = is_ldr_w;
              mem_wr_o  = is_st_w;
              ra2sel_o  = is_st_w;
              if (ack_w) begin
                pc_en_o = 1'b1;
                if (!is_st_w) begin
                  werf_o  = 1'b1;
                  wdsel_o = 2'd2;
                end
              end
            end
          end
        end
        S_ILL: begin
          wasel_o = 1'b1;
          werf_o  = 1'b1;
          pcsel_o = 3'd3;
          pc_en_o = 1'b1;
          illop_o = 1'b1;
        end
        S_INT: begin
          wasel_o   = 1'b1;
          werf_o    = 1'b1;
          pcsel_o   = 3'd4;
          pc_en_o   = 1'b1;
          irq_ack_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beta_mc_ctrl.sv
`default_nettype none
// tb_beta_mc_ctrl: directed checks of beta_mc_ctrl with WAIT_MAX=4.
// Revision: 1.0
module tb_beta_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ack, z, irq;
  logic        mem_req, mem_wr, imem_sel, ra2sel, wasel, werf, asel, bsel;
  logic [4:0]  ra, rb, rc;
  logic [3:0]  alufn;
  logic [1:0]  wdsel;
  logic [2:0]  pcsel;
  logic        pc_en, irq_ack, illop, bus_err;

  int n_asserts = 0;
  int n_fail    = 0;

  logic        e_mem_req, e_mem_wr, e_imem_sel, e_ra2sel, e_wasel, e_werf, e_asel, e_bsel;
  logic [3:0]  e_alufn;
  logic [1:0]  e_wdsel;
  logic [2:0]  e_pcsel;
  logic        e_pc_en, e_irq_ack, e_illop, e_bus_err;

  always #5 clk = ~clk;

  beta_mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .mem_ack_i(mem_ack), .z_i(z), .irq_i(irq),
    .mem_req_o(mem_req), .mem_wr_o(mem_wr), .imem_sel_o(imem_sel),
    .ra_o(ra), .rb_o(rb), .rc_o(rc), .ra2sel_o(ra2sel), .wasel_o(wasel), .werf_o(werf),
    .asel_o(asel), .bsel_o(bsel), .alufn_o(alufn), .wdsel_o(wdsel), .pcsel_o(pcsel),
    .pc_en_o(pc_en), .irq_ack_o(irq_ack), .illop_o(illop), .bus_err_o(bus_err)
  );

  task automatic clr;
    {e_mem_req, e_mem_wr, e_imem_sel, e_ra2sel, e_wasel, e_werf, e_asel, e_bsel} = '0;
    e_alufn = '0; e_wdsel = '0; e_pcsel = '0;
    {e_pc_en, e_irq_ack, e_illop, e_bus_err} = '0;
  endtask

  task automatic exp_fetch;
    clr(); e_mem_req = 1'b1; e_imem_sel = 1'b1;
  endtask

  task automatic chk_ctl(input string tag);
    logic [20:0] obs, exp;
    obs = {mem_req, mem_wr, imem_sel, ra2sel, wasel, werf, asel, bsel, alufn, wdsel, pcsel,
           pc_en, irq_ack, illop, bus_err};
    exp = {e_mem_req, e_mem_wr, e_imem_sel, e_ra2sel, e_wasel, e_werf, e_asel, e_bsel, e_alufn,
           e_wdsel, e_pcsel, e_pc_en, e_irq_ack, e_illop, e_bus_err};
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: controls observed=%b expected=%b (req,wr,isel,ra2,wasel,werf,asel,bsel,alufn,wdsel,pcsel,pcen,iack,ill,berr)",
             tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 unit after the edge, outputs are sampled 1 unit later.
  task automatic cyc(input logic ack, input logic zz, input logic ir);
    @(posedge clk);
    #1;
    mem_ack = ack; z = zz; irq = ir;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; mem_ack = 1'b0; z = 1'b0; irq = 1'b0;
    #2;
    clr(); chk_ctl("reset");
    chk("reset_ra", 32'(ra), 0); chk("reset_rc", 32'(rc), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 clr(); chk_ctl("release_before_edge");

    // ADD R1,R2,R3 with ack on the third FETCH cycle
    instr = 32'h8061_1000;
    cyc(0, 0, 0); exp_fetch(); chk_ctl("add_fetch0");
    cyc(0, 0, 0); exp_fetch(); chk_ctl("add_fetch1");
    cyc(1, 0, 0); exp_fetch(); chk_ctl("add_fetch_ack");
    cyc(0, 0, 0); clr(); chk_ctl("add_decode");
    chk("add_ra", 32'(ra), 1); chk("add_rb", 32'(rb), 2); chk("add_rc", 32'(rc), 3);
    cyc(0, 0, 0); clr(); e_werf = 1; e_wdsel = 2'd1; e_pc_en = 1; chk_ctl("add_exec");

    // ST R5,8(R1): three wait cycles then ack
    instr = 32'h64A1_0008;
    cyc(1, 0, 0); exp_fetch(); chk_ctl("st_fetch");
    cyc(0, 0, 0); clr(); chk_ctl("st_decode");
    chk("st_rc", 32'(rc), 5); chk("st_ra", 32'(ra), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0); clr(); e_mem_req = 1; e_mem_wr = 1; e_ra2sel = 1; e_bsel = 1;
      chk_ctl("st_exec_wait");
    end
    cyc(1, 0, 0); clr(); e_mem_req = 1; e_mem_wr = 1; e_ra2sel = 1; e_bsel = 1; e_pc_en = 1;
    chk_ctl("st_exec_ack");

    // BEQ: Z is combinational, so both Z values are checked within the EXEC cycle
    instr = 32'h7041_0004;
    cyc(0, 0, 0); exp_fetch(); chk_ctl("beq_back_to_fetch");
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0); clr(); e_werf = 1; e_pc_en = 1; e_pcsel = 3'd1; chk_ctl("beq_z1");
    z = 1'b0; #1 e_pcsel = 3'd0; chk_ctl("beq_z0");

    // BNE: inverse branch decision
    instr = 32'h7441_0004;
    cyc(1, 0, 0); exp_fetch(); chk_ctl("bne_fetch");
    cyc(0, 0, 0);
    cyc(0, 1, 0); clr(); e_werf = 1; e_pc_en = 1; e_pcsel = 3'd0; chk_ctl("bne_z1");
    z = 1'b0; #1 e_pcsel = 3'd1; chk_ctl("bne_z0");

    // LDR R1 with zero-wait memory
    instr = 32'h7C20_0000;
    cyc(1, 0, 0); exp_fetch(); chk_ctl("ldr_fetch");
    cyc(0, 0, 0);
    cyc(1, 0, 0); clr(); e_mem_req = 1; e_bsel = 1; e_asel = 1; e_pc_en = 1; e_werf = 1;
    e_wdsel = 2'd2; chk_ctl("ldr_exec_ack");

    // Illegal opcode 0x27
    instr = 32'h9C00_0000;
    cyc(1, 0, 0); exp_fetch(); chk_ctl("ill_fetch");
    cyc(0, 0, 0); clr(); chk_ctl("ill_decode");
    cyc(0, 0, 0); clr(); e_wasel = 1; e_werf = 1; e_pcsel = 3'd3; e_pc_en = 1; e_illop = 1;
    chk_ctl("ill_state");
    cyc(0, 0, 0); exp_fetch(); chk_ctl("ill_then_fetch");

    // IRQ raised during an ADD EXEC
    instr = 32'h8061_1000;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1); clr(); e_werf = 1; e_wdsel = 2'd1; e_pc_en = 1; chk_ctl("irq_exec");
    cyc(0, 0, 1); clr(); e_wasel = 1; e_werf = 1; e_pcsel = 3'd4; e_pc_en = 1; e_irq_ack = 1;
    chk_ctl("irq_int");
    cyc(0, 0, 1); exp_fetch(); chk_ctl("irq_then_fetch");
    cyc(0, 0, 0); exp_fetch(); chk_ctl("irq_fetch_hold");

    // LD with no ack: four request cycles, then BUS_ERR, then ILL
    instr = 32'h6000_0000;
    cyc(1, 0, 0); exp_fetch(); chk_ctl("ld_fetch");
    cyc(1, 0, 0); clr(); chk_ctl("ld_decode_stray_ack");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0); clr(); e_mem_req = 1; e_bsel = 1; chk_ctl("ld_exec_wait");
    end
    cyc(0, 0, 0); clr(); e_bus_err = 1; chk_ctl("ld_timeout");
    cyc(0, 0, 0); clr(); e_wasel = 1; e_werf = 1; e_pcsel = 3'd3; e_pc_en = 1; e_illop = 1;
    chk_ctl("ld_timeout_ill");
    cyc(0, 0, 0); exp_fetch(); chk_ctl("ld_timeout_fetch");

    // Reset in the middle of a data wait
    instr = 32'h60A2_0000;
    cyc(1, 0, 0);
    cyc(0, 0, 0); chk("rst_pre_rc", 32'(rc), 5);
    cyc(0, 0, 0); clr(); e_mem_req = 1; e_bsel = 1; chk_ctl("rst_pre_wait");
    rst_n = 1'b0;
    #1 clr(); chk_ctl("rst_async");
    chk("rst_ra", 32'(ra), 0); chk("rst_rc", 32'(rc), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 clr(); chk_ctl("rst_release_before_edge");
    cyc(0, 0, 0); exp_fetch(); chk_ctl("rst_fetch");
    chk("rst_ir_ra", 32'(ra), 0); chk("rst_ir_rc", 32'(rc), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
